// File: rtl/fir_pkg.sv
// Shared types and defaults for the serial FIR tap sequencer.
package fir_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StHold
  } fir_state_e;

  localparam int unsigned DefTaps  = 5;
  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefAccW  = 40;

  // Width of a tap index; never narrower than one bit.
  function automatic int unsigned tap_idx_w(input int unsigned taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// Sample-in, result-out and coefficient-write signals of the tap sequencer.
interface fir_tap_sequencer_if #(
  parameter int unsigned TAPS   = fir_pkg::DefTaps,
  parameter int unsigned DATA_W = fir_pkg::DefDataW,
  parameter int unsigned ACC_W  = fir_pkg::DefAccW
);
  localparam int unsigned AW = fir_pkg::tap_idx_w(TAPS);

  logic              inValid;
  logic              inReady;
  logic [DATA_W-1:0] inSample;
  logic              coefWe;
  logic [AW-1:0]     coefAddr;
  logic [DATA_W-1:0] coefData;
  logic              coefReject;
  logic              outValid;
  logic              outReady;
  logic [DATA_W-1:0] outSample;
  logic [ACC_W-1:0]  outWide;
  logic              busy;

  modport master (
    output inValid, inSample, coefWe, coefAddr, coefData, outReady,
    input  inReady, coefReject, outValid, outSample, outWide, busy
  );

  modport slave (
    input  inValid, inSample, coefWe, coefAddr, coefData, outReady,
    output inReady, coefReject, outValid, outSample, outWide, busy
  );

endinterface

// File: rtl/fir_mac_unit.sv
// Combinational signed multiply-accumulate: acc_out = acc_in + coef * sample.
module fir_mac_unit #(
  parameter int unsigned DATA_W = fir_pkg::DefDataW,
  parameter int unsigned ACC_W  = fir_pkg::DefAccW
) (
  input  logic signed [ACC_W-1:0]  acc_in,
  input  logic signed [DATA_W-1:0] coef,
  input  logic signed [DATA_W-1:0] sample,
  output logic signed [ACC_W-1:0]  acc_out
);

  logic signed [2*DATA_W-1:0] product;

  assign product = coef * sample;
  assign acc_out = acc_in + {{(ACC_W - 2*DATA_W){product[2*DATA_W-1]}}, product};

endmodule

// File: rtl/fir_tap_sequencer.sv
// Serial FIR: one MAC time-shared over TAPS coefficient/sample pairs per input sample,
// with the sample history, coefficient file and both handshakes kept here.
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int unsigned TAPS   = DefTaps,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ACC_W  = DefAccW
) (
  input logic                 clock,
  input logic                 resetN,
  fir_tap_sequencer_if.slave  bus
);

  localparam int unsigned AW = tap_idx_w(TAPS);
  localparam logic [AW-1:0] LastTap = AW'(TAPS - 1);

  fir_state_e state_q, state_d;

  logic signed [DATA_W-1:0] hist_q [TAPS];
  logic signed [DATA_W-1:0] coef_q [TAPS];
  logic signed [ACC_W-1:0]  acc_q, acc_next;
  logic [AW-1:0]            tap_q;
  logic                     out_valid_q;
  logic [DATA_W-1:0]        out_sample_q;
  logic [ACC_W-1:0]         out_wide_q;
  logic                     coef_reject_q;

  logic accept, coef_ok, last_tap;

  assign accept   = (state_q == StIdle) && bus.inValid;
  assign coef_ok  = (state_q == StIdle) && (32'(bus.coefAddr) < TAPS);
  assign last_tap = (tap_q == LastTap);

  fir_mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .acc_in  (acc_q),
    .coef    (coef_q[tap_q]),
    .sample  (hist_q[tap_q]),
    .acc_out (acc_next)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.inValid)  state_d = StMac;
      StMac:   if (last_tap)     state_d = StHold;
      StHold:  if (bus.outReady) state_d = StIdle;
      default:                   state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.inReady = (state_q == StIdle);
    bus.busy    = (state_q != StIdle);
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < int'(TAPS); i++) begin
        hist_q[i] <= '0;
        coef_q[i] <= '0;
      end
      acc_q         <= '0;
      tap_q         <= '0;
      out_valid_q   <= 1'b0;
      out_sample_q  <= '0;
      out_wide_q    <= '0;
      coef_reject_q <= 1'b0;
    end else begin
      coef_reject_q <= bus.coefWe && !coef_ok;
      // A write landing with an accept is visible to that sample's MAC pass.
      if (bus.coefWe && coef_ok) begin
        coef_q[bus.coefAddr] <= bus.coefData;
      end
      if (accept) begin
        hist_q[0] <= bus.inSample;
        for (int i = 1; i < int'(TAPS); i++) begin
          hist_q[i] <= hist_q[i-1];
        end
        acc_q <= '0;
        tap_q <= '0;
      end else if (state_q == StMac) begin
        acc_q <= acc_next;
        tap_q <= tap_q + 1'b1;
        if (last_tap) begin
          out_valid_q  <= 1'b1;
          out_wide_q   <= acc_next;
          out_sample_q <= acc_next[DATA_W-1:0];
        end
      end else if ((state_q == StHold) && bus.outReady) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.outValid   = out_valid_q;
  assign bus.outSample  = out_sample_q;
  assign bus.outWide    = out_wide_q;
  assign bus.coefReject = coef_reject_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer: a dot-product model checked every cycle plus
// hand-computed literal results.
module tb_fir_tap_sequencer;

  localparam int unsigned TAPS   = 5;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ACC_W  = 40;

  logic clock = 1'b0;
  logic resetN;
  int   checks = 0;
  int   errors = 0;

  fir_tap_sequencer_if #(.TAPS(TAPS), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

  fir_tap_sequencer #(
    .TAPS   (TAPS),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: filter output is the dot product of coefficients and the newest TAPS samples;
  // result appears TAPS edges after accept and is held until outReady.
  int               m_hist [TAPS];
  int               m_coef [TAPS];
  bit               m_run;
  int               m_cnt;
  logic [ACC_W-1:0] m_wide;
  logic [ACC_W-1:0] m_pend;
  bit               m_rej;
  bit               m_was_idle;

  function automatic logic [ACC_W-1:0] dot();
    longint s = 0;
    for (int i = 0; i < int'(TAPS); i++) s += longint'(m_coef[i]) * longint'(m_hist[i]);
    return ACC_W'(s);
  endfunction

  initial begin
    forever begin
      @(posedge clock);
      if (!resetN) begin
        for (int i = 0; i < int'(TAPS); i++) begin
          m_hist[i] = 0;
          m_coef[i] = 0;
        end
        m_run  = 1'b0;
        m_cnt  = 0;
        m_wide = '0;
        m_rej  = 1'b0;
      end else begin
        m_was_idle = !m_run;
        m_rej      = 1'b0;
        if (bus.coefWe) begin
          if (m_was_idle && (bus.coefAddr < TAPS)) m_coef[bus.coefAddr] = int'($signed(bus.coefData));
          else m_rej = 1'b1;
        end
        if (m_was_idle) begin
          if (bus.inValid) begin
            for (int i = int'(TAPS) - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = int'($signed(bus.inSample));
            m_pend    = dot();
            m_run     = 1'b1;
            m_cnt     = 0;
          end
        end else if (m_cnt >= int'(TAPS)) begin
          if (bus.outReady) m_run = 1'b0;
        end else begin
          m_cnt++;
          if (m_cnt == int'(TAPS)) m_wide = m_pend;
        end
      end
      #1;
      chk("inReady", bus.inReady, !m_run);
      chk("busy", bus.busy, m_run);
      chk("outValid", bus.outValid, m_run && (m_cnt >= int'(TAPS)));
      chk("outWide", bus.outWide, m_wide);
      chk("outSample", bus.outSample, m_wide[DATA_W-1:0]);
      chk("coefReject", bus.coefReject, m_rej);
    end
  end

  task automatic do_reset();
    @(negedge clock);
    resetN = 1'b0;
    repeat (2) @(negedge clock);
    resetN = 1'b1;
  endtask

  task automatic write_coef(input logic [2:0] addr, input logic [15:0] data, output logic rej);
    @(negedge clock);
    bus.coefWe   = 1'b1;
    bus.coefAddr = addr;
    bus.coefData = data;
    @(posedge clock);
    #1 rej = bus.coefReject;
    @(negedge clock);
    bus.coefWe = 1'b0;
  endtask

  task automatic send_wc(input logic [15:0] s, input logic we, input logic [2:0] addr,
                         input logic [15:0] data);
    int n = 0;
    @(negedge clock);
    while (!bus.inReady && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) chk("send_timeout", 1, 0);
    bus.inValid  = 1'b1;
    bus.inSample = s;
    bus.coefWe   = we;
    bus.coefAddr = addr;
    bus.coefData = data;
    @(negedge clock);
    bus.inValid = 1'b0;
    bus.coefWe  = 1'b0;
  endtask

  task automatic send(input logic [15:0] s);
    send_wc(s, 1'b0, 3'd0, 16'd0);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.outValid && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) chk("result_timeout", 1, 0);
  endtask

  task automatic get_result(output logic [ACC_W-1:0] wide, output logic [15:0] samp);
    wait_valid();
    wide = bus.outWide;
    samp = bus.outSample;
    bus.outReady = 1'b1;
    @(negedge clock);
    bus.outReady = 1'b0;
  endtask

  task automatic set_coefs(input int c0, input int c1, input int c2, input int c3, input int c4);
    logic r;
    int   c [5];
    c = '{c0, c1, c2, c3, c4};
    for (int i = 0; i < 5; i++) begin
      write_coef(3'(i), 16'(c[i]), r);
      chk("coef_accept", r, 1'b0);
    end
  endtask

  logic [ACC_W-1:0] w;
  logic [15:0]      sm;
  logic             rj;

  initial begin
    resetN       = 1'b0;
    bus.inValid  = 1'b0;
    bus.inSample = '0;
    bus.coefWe   = 1'b0;
    bus.coefAddr = '0;
    bus.coefData = '0;
    bus.outReady = 1'b0;
    repeat (3) @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
    chk("reset_inReady", bus.inReady, 1'b1);
    chk("reset_outValid", bus.outValid, 1'b0);
    chk("reset_outWide", bus.outWide, 0);

    // Identity filter
    set_coefs(1, 0, 0, 0, 0);
    send(16'd7);    get_result(w, sm);
    chk("id_7", sm, 16'd7);
    send(16'hFFFD); get_result(w, sm);
    chk("id_m3", sm, 16'hFFFD);
    chk("id_m3_wide", w, 40'hFF_FFFF_FFFD);
    send(16'd100);  get_result(w, sm);
    chk("id_100", sm, 16'd100);

    // Ramp coefficients with a unit step
    do_reset();
    set_coefs(1, 2, 3, 4, 5);
    send(16'd1); get_result(w, sm); chk("ramp_1", sm, 16'd1);
    send(16'd1); get_result(w, sm); chk("ramp_3", sm, 16'd3);
    send(16'd1); get_result(w, sm); chk("ramp_6", sm, 16'd6);
    send(16'd1); get_result(w, sm); chk("ramp_10", sm, 16'd10);
    send(16'd1); get_result(w, sm); chk("ramp_15", sm, 16'd15);
    chk("ramp_15_wide", w, 40'd15);

    // Full-scale wrap
    do_reset();
    set_coefs(32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF);
    repeat (5) begin
      send(16'h7FFF);
      get_result(w, sm);
    end
    chk("wrap_wide", w, 40'h1_3FFB_0005);
    chk("wrap_sample", sm, 16'h0005);

    // Backpressure in HOLD; a pending sample must not be taken
    send(16'd0);
    wait_valid();
    bus.inValid  = 1'b1;
    bus.inSample = 16'h1234;
    repeat (10) @(negedge clock);
    chk("hold_inReady", bus.inReady, 1'b0);
    chk("hold_outValid", bus.outValid, 1'b1);
    chk("hold_wide", bus.outWide, 40'h00_FFFC_0004);
    chk("hold_sample", bus.outSample, 16'h0004);
    bus.inValid  = 1'b0;
    bus.outReady = 1'b1;
    @(negedge clock);
    bus.outReady = 1'b0;
    chk("release_inReady", bus.inReady, 1'b1);
    chk("release_outValid", bus.outValid, 1'b0);

    // Rejected coefficient writes: during MAC, and out-of-range address in IDLE
    send(16'd2);
    write_coef(3'd0, 16'd1, rj);
    chk("rej_mac", rj, 1'b1);
    get_result(w, sm);
    chk("rej_mac_wide", w, 40'h00_BFFE_0001);
    write_coef(3'd5, 16'd9, rj);
    chk("rej_addr", rj, 1'b1);
    send(16'd0); get_result(w, sm);
    chk("rej_addr_wide", w, 40'h00_7FFF_0000);

    // Reset mid-MAC aborts and clears history and coefficients
    send(16'd5);
    repeat (2) @(negedge clock);
    resetN = 1'b0;
    repeat (2) @(negedge clock);
    chk("abort_outValid", bus.outValid, 1'b0);
    chk("abort_busy", bus.busy, 1'b0);
    resetN = 1'b1;
    set_coefs(2, 1, 1, 1, 1);
    send(16'd9); get_result(w, sm);
    chk("after_reset_18", sm, 16'd18);

    // Coefficient write in the same cycle as accept is used by that sample
    send_wc(16'd1, 1'b1, 3'd0, 16'd3);
    get_result(w, sm);
    chk("same_cycle_12", sm, 16'd12);

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

endmodule
